// File: rtl/cr_kme_fifo_writer_pkg.sv
// Shared types and constants for the KME FIFO write-side driver.
package cr_kme_fifo_writer_pkg;

  typedef enum logic [0:0] {WR_IDLE, WR_SEND} wr_state_e;

  localparam int WORDS_CNT_W = 16;

endpackage

// File: rtl/cr_kme_fifo_writer.sv
// KME FIFO writer: takes wide words from a ready/valid source, serialises
// them into BEATS beats of DATA_SIZE bits and pushes them into a stall-based
// KME FIFO. It never pushes while stalled, and it flags FIFO overflow and
// prolonged stalls with sticky bits.
// Build option: define CR_KME_FIFO_WRITER_MSB_FIRST_EN to send the most
// significant beat first. By default the least significant beat goes first.
module cr_kme_fifo_writer
  import cr_kme_fifo_writer_pkg::*;
#(
  parameter int DATA_SIZE     = 8,
  parameter int BEATS         = 4,
  parameter int STALL_TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_SIZE*BEATS-1:0] req_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  output logic [DATA_SIZE-1:0]       fifo_in,
  output logic                       fifo_in_valid,
  input  logic                       fifo_in_stall,
  input  logic                       fifo_overflow,
  output logic                       busy,
  output logic [15:0]                words_sent,
  output logic                       err_overflow,
  output logic                       stall_timeout
);

  localparam int WORD_W      = DATA_SIZE * BEATS;
  localparam int BEAT_CNT_W  = $clog2(BEATS);
  localparam int STALL_CNT_W = $clog2(STALL_TIMEOUT + 1);

  localparam logic [BEAT_CNT_W-1:0]  LAST_BEAT = BEAT_CNT_W'(BEATS - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = STALL_CNT_W'(STALL_TIMEOUT);

  wr_state_e               state_q, state_d;
  logic [WORD_W-1:0]       shift_q, shift_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WORDS_CNT_W-1:0]  words_sent_q, words_sent_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                    err_overflow_q, err_overflow_d;
  logic                    stall_timeout_q, stall_timeout_d;

  logic                    push;
  logic                    last_beat;
  logic [DATA_SIZE-1:0]    cur_beat;
  logic [WORD_W-1:0]       shift_next;

  // Registers all state, with a synchronous reset that drops any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= WR_IDLE;
      shift_q         <= '0;
      beat_cnt_q      <= '0;
      words_sent_q    <= '0;
      stall_cnt_q     <= '0;
      err_overflow_q  <= 1'b0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      beat_cnt_q      <= beat_cnt_d;
      words_sent_q    <= words_sent_d;
      stall_cnt_q     <= stall_cnt_d;
      err_overflow_q  <= err_overflow_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  // Computes the next FSM state, shift register, counters and sticky flags.
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    beat_cnt_d      = beat_cnt_q;
    words_sent_d    = words_sent_q;
    stall_cnt_d     = stall_cnt_q;
    err_overflow_d  = err_overflow_q;
    stall_timeout_d = stall_timeout_q;

    case (state_q)
      WR_IDLE: begin
        if (req_valid) begin
          shift_d    = req_data;
          beat_cnt_d = '0;
          state_d    = WR_SEND;
        end
      end
      WR_SEND: begin
        if (push) begin
          if (last_beat) begin
            words_sent_d = words_sent_q + WORDS_CNT_W'(1);
            beat_cnt_d   = '0;
            if (req_valid) begin
              shift_d = req_data;
              state_d = WR_SEND;
            end else begin
              shift_d = '0;
              state_d = WR_IDLE;
            end
          end else begin
            shift_d    = shift_next;
            beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          end
        end
      end
      default: state_d = WR_IDLE;
    endcase

    if (push) begin
      stall_cnt_d = '0;
    end else if (busy && fifo_in_stall && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    if (stall_cnt_d == STALL_MAX) begin
      stall_timeout_d = 1'b1;
    end

    if (fifo_overflow) begin
      err_overflow_d = 1'b1;
    end
  end

  // Drives the FIFO push, the upstream ready and the status outputs directly from state.
  always_comb begin
    busy          = (state_q == WR_SEND);
    fifo_in_valid = busy && !fifo_in_stall;
    push          = fifo_in_valid;
    last_beat     = (beat_cnt_q == LAST_BEAT);
    req_ready     = !rst && ((state_q == WR_IDLE) || (push && last_beat));
`ifdef CR_KME_FIFO_WRITER_MSB_FIRST_EN
    cur_beat      = shift_q[WORD_W-1 -: DATA_SIZE];
    shift_next    = shift_q << DATA_SIZE;
`else
    cur_beat      = shift_q[DATA_SIZE-1:0];
    shift_next    = shift_q >> DATA_SIZE;
`endif
    fifo_in       = busy ? cur_beat : '0;
    words_sent    = words_sent_q;
    err_overflow  = err_overflow_q;
    stall_timeout = stall_timeout_q;
  end

endmodule

// File: tb/tb_cr_kme_fifo_writer.sv
// Testbench for cr_kme_fifo_writer. A queue-based model of the pending beats
// is checked against the DUT on every negative edge. Directed checks against
// hand-computed literals cover basic send, back-to-back words, stall hold,
// mid-word reset, overflow stickiness and stall timeout.
// Honours CR_KME_FIFO_WRITER_MSB_FIRST_EN for the expected beat order.
module tb_cr_kme_fifo_writer;

  localparam int DS = 8;
  localparam int NB = 4;
  localparam int TO = 4;
`ifdef CR_KME_FIFO_WRITER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   req_data;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    fifo_in;
  logic          fifo_in_valid;
  logic          fifo_in_stall;
  logic          fifo_overflow;
  logic          busy;
  logic [15:0]   words_sent;
  logic          err_overflow;
  logic          stall_timeout;

  int numChecks = 0;
  int numFails  = 0;

  // Model state: beats still to be pushed for the word in flight.
  logic [7:0] mBeats[$];
  int         mWords = 0;
  bit         mErr = 1'b0;
  bit         mTo = 1'b0;
  int         mStallRun = 0;
  bit         mValid = 1'b0;
  bit         mReady;

  // Log of observed pushes with the negedge index they happened on.
  logic [7:0] logData[$];
  int         logTs[$];
  int         cycleCnt = 0;

  cr_kme_fifo_writer #(
    .DATA_SIZE(DS),
    .BEATS(NB),
    .STALL_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_data(req_data),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .fifo_in(fifo_in),
    .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(fifo_in_stall),
    .fifo_overflow(fifo_overflow),
    .busy(busy),
    .words_sent(words_sent),
    .err_overflow(err_overflow),
    .stall_timeout(stall_timeout)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a word and waits (bounded) for the handshake; reports the beat on the bus at acceptance.
  task automatic applyStimulus(input logic [31:0] w, input bit keepValid, output logic [7:0] beatAtAccept);
    bit done;
    done = 1'b0;
    beatAtAccept = '0;
    req_data  = w;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        beatAtAccept = fifo_in;
        done = 1'b1;
      end
    end
    if (!done) begin
      checkOutput("handshake_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    if (!keepValid) req_valid = 1'b0;
  endtask

  function automatic logic [31:0] logPacked(input int start);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (start + i < logData.size()) r = {r[23:0], logData[start + i]};
      else r = {r[23:0], 8'h00};
    end
    return r;
  endfunction

  task automatic clearLog();
    logData.delete();
    logTs.delete();
  endtask

  // Model update: consumes a beat on each unstalled cycle and loads words on handshake.
  always @(posedge clk) begin
    if (rst) begin
      mBeats.delete();
      mWords    = 0;
      mErr      = 1'b0;
      mTo       = 1'b0;
      mStallRun = 0;
      mValid    = 1'b1;
    end else if (mValid) begin
      mReady = (mBeats.size() == 0) || (mBeats.size() == 1 && !fifo_in_stall);
      if (mBeats.size() > 0) begin
        if (!fifo_in_stall) begin
          void'(mBeats.pop_front());
          if (mBeats.size() == 0) mWords = (mWords + 1) % 65536;
          mStallRun = 0;
        end else begin
          if (mStallRun < TO) mStallRun++;
          if (mStallRun == TO) mTo = 1'b1;
        end
      end
      if (mReady && req_valid) begin
        for (int i = 0; i < NB; i++) begin
          if (MSB) mBeats.push_back(req_data[(NB-1-i)*DS +: DS]);
          else     mBeats.push_back(req_data[i*DS +: DS]);
        end
      end
      if (fifo_overflow) mErr = 1'b1;
    end
  end

  // Compare process: checks every output against the model each cycle outside reset.
  always @(negedge clk) begin
    bit bExp;
    if (mValid && !rst) begin
      bExp = (mBeats.size() > 0);
      checkOutput("busy", {31'd0, busy}, {31'd0, bExp});
      checkOutput("fifo_in_valid", {31'd0, fifo_in_valid}, {31'd0, bExp && !fifo_in_stall});
      checkOutput("fifo_in", {24'd0, fifo_in}, bExp ? {24'd0, mBeats[0]} : 32'd0);
      checkOutput("req_ready", {31'd0, req_ready},
                  {31'd0, !bExp || (mBeats.size() == 1 && !fifo_in_stall)});
      checkOutput("words_sent", {16'd0, words_sent}, 32'(mWords));
      checkOutput("err_overflow", {31'd0, err_overflow}, {31'd0, mErr});
      checkOutput("stall_timeout", {31'd0, stall_timeout}, {31'd0, mTo});
    end
  end

  // Push logger.
  always @(negedge clk) begin
    cycleCnt++;
    if (fifo_in_valid === 1'b1) begin
      logData.push_back(fifo_in);
      logTs.push_back(cycleCnt);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [7:0] acc;
    rst = 1'b1;
    req_data = '0;
    req_valid = 1'b0;
    fifo_in_stall = 1'b0;
    fifo_overflow = 1'b0;
    tick(2);
    @(negedge clk);
    checkOutput("ready_in_reset", {31'd0, req_ready}, 32'd0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, fifo_in_valid}, 32'd0);
    checkOutput("rst_fifo_in", {24'd0, fifo_in}, 32'd0);
    checkOutput("rst_words", {16'd0, words_sent}, 32'd0);
    checkOutput("rst_flags", {30'd0, err_overflow, stall_timeout}, 32'd0);
    checkOutput("rst_ready_idle", {31'd0, req_ready}, 32'd1);
    tick(1);

    // T1 basic
    $display("[TB] T1 basic");
    clearLog();
    applyStimulus(32'h44332211, 1'b0, acc);
    tick(6);
    @(negedge clk);
    checkOutput("t1_beats", logPacked(0), MSB ? 32'h44332211 : 32'h11223344);
    checkOutput("t1_count", 32'(logData.size()), 32'd4);
    checkOutput("t1_words", {16'd0, words_sent}, 32'd1);
    checkOutput("t1_busy", {31'd0, busy}, 32'd0);
    tick(1);

    // T2 back-to-back
    $display("[TB] T2 back-to-back");
    clearLog();
    applyStimulus(32'hA3A2A1A0, 1'b1, acc);
    applyStimulus(32'hB3B2B1B0, 1'b0, acc);
    checkOutput("t2_ready_on_last_push", {24'd0, acc}, MSB ? 32'hA0 : 32'hA3);
    tick(6);
    @(negedge clk);
    checkOutput("t2_beats_a", logPacked(0), MSB ? 32'hA3A2A1A0 : 32'hA0A1A2A3);
    checkOutput("t2_beats_b", logPacked(4), MSB ? 32'hB3B2B1B0 : 32'hB0B1B2B3);
    checkOutput("t2_count", 32'(logData.size()), 32'd8);
    checkOutput("t2_contiguous", (logData.size() == 8) ? 32'(logTs[7] - logTs[0]) : 32'hFFFF, 32'd7);
    checkOutput("t2_words", {16'd0, words_sent}, 32'd3);
    tick(1);

    // T3 stall after two beats
    $display("[TB] T3 stall");
    clearLog();
    applyStimulus(32'h44332211, 1'b0, acc);
    tick(2);
    fifo_in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t3_stall_valid", {31'd0, fifo_in_valid}, 32'd0);
      checkOutput("t3_stall_hold", {24'd0, fifo_in}, MSB ? 32'h22 : 32'h33);
      tick(1);
    end
    fifo_in_stall = 1'b0;
    tick(4);
    @(negedge clk);
    checkOutput("t3_beats", logPacked(0), MSB ? 32'h44332211 : 32'h11223344);
    checkOutput("t3_count", 32'(logData.size()), 32'd4);
    checkOutput("t3_words", {16'd0, words_sent}, 32'd4);
    checkOutput("t3_no_timeout", {31'd0, stall_timeout}, 32'd0);
    tick(1);

    // T5 reset mid-word
    $display("[TB] T5 reset mid-word");
    applyStimulus(32'hDDCCBBAA, 1'b0, acc);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_words", {16'd0, words_sent}, 32'd0);
    checkOutput("t5_valid", {31'd0, fifo_in_valid}, 32'd0);
    tick(1);
    clearLog();
    applyStimulus(32'h44332211, 1'b0, acc);
    tick(6);
    @(negedge clk);
    checkOutput("t5_restart_beats", logPacked(0), MSB ? 32'h44332211 : 32'h11223344);
    checkOutput("t5_restart_words", {16'd0, words_sent}, 32'd1);
    tick(1);

    // Overflow pulse is sticky
    $display("[TB] overflow sticky");
    fifo_overflow = 1'b1;
    tick(1);
    fifo_overflow = 1'b0;
    @(negedge clk);
    checkOutput("ovf_set", {31'd0, err_overflow}, 32'd1);
    tick(3);
    @(negedge clk);
    checkOutput("ovf_sticky", {31'd0, err_overflow}, 32'd1);
    tick(1);

    // T4 stall timeout
    $display("[TB] T4 timeout");
    clearLog();
    applyStimulus(32'h44332211, 1'b0, acc);
    fifo_in_stall = 1'b1;
    tick(3);
    @(negedge clk);
    checkOutput("t4_before", {31'd0, stall_timeout}, 32'd0);
    tick(1);
    @(negedge clk);
    checkOutput("t4_set", {31'd0, stall_timeout}, 32'd1);
    tick(2);
    fifo_in_stall = 1'b0;
    tick(6);
    @(negedge clk);
    checkOutput("t4_sticky", {31'd0, stall_timeout}, 32'd1);
    checkOutput("t4_beats", logPacked(0), MSB ? 32'h44332211 : 32'h11223344);
    checkOutput("t4_words", {16'd0, words_sent}, 32'd2);
    tick(1);

    // Reset clears the sticky flags
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("final_timeout_clr", {31'd0, stall_timeout}, 32'd0);
    checkOutput("final_ovf_clr", {31'd0, err_overflow}, 32'd0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
